// File: rtl/fwd_hazard_if.sv
// Forwarding / hazard bundle between pipeline control and the hazard unit.
// Carries ID, EX, MEM and WB register-use info plus the unit's decisions.
interface fwd_hazard_if #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);
    logic                      id_valid;
    logic [NUM_SRC*ADDR_W-1:0] id_src_addr;
    logic [NUM_SRC-1:0]        id_src_used;
    logic                      id_reg_write;
    logic [ADDR_W-1:0]         id_write_addr;
    logic                      id_is_mdu;
    logic                      flush;
    logic [NUM_SRC*ADDR_W-1:0] id_ex_src_addr;
    logic                      id_ex_reg_write;
    logic                      id_ex_is_load;
    logic [ADDR_W-1:0]         id_ex_write_addr;
    logic                      ex_mem_reg_write;
    logic [ADDR_W-1:0]         ex_mem_write_reg_addr;
    logic                      mem_wb_reg_write;
    logic [ADDR_W-1:0]         mem_wb_write_reg_addr;
    logic [2*NUM_SRC-1:0]      forward_sel;
    logic                      stall;
    logic                      mdu_busy;
    logic [CNT_W-1:0]          stall_count;

    modport master (
        output id_valid, id_src_addr, id_src_used,
        output id_reg_write, id_write_addr, id_is_mdu, flush,
        output id_ex_src_addr, id_ex_reg_write,
        output id_ex_is_load, id_ex_write_addr,
        output ex_mem_reg_write, ex_mem_write_reg_addr,
        output mem_wb_reg_write, mem_wb_write_reg_addr,
        input  forward_sel, stall, mdu_busy, stall_count
    );

    modport slave (
        input  id_valid, id_src_addr, id_src_used,
        input  id_reg_write, id_write_addr, id_is_mdu, flush,
        input  id_ex_src_addr, id_ex_reg_write,
        input  id_ex_is_load, id_ex_write_addr,
        input  ex_mem_reg_write, ex_mem_write_reg_addr,
        input  mem_wb_reg_write, mem_wb_write_reg_addr,
        output forward_sel, stall, mdu_busy, stall_count
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects, load-use / MDU hazard stall generation,
// MDU result countdown tracking and a saturating stall cycle counter.
module fwd_hazard_unit #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       reset,
    fwd_hazard_if.slave bus
);
    localparam int LAT_W = 4;

    typedef logic [ADDR_W-1:0] addr_t;

    logic [LAT_W-1:0]     cnt_q;
    addr_t                dst_q;
    logic [CNT_W-1:0]     scnt_q;
    logic [2*NUM_SRC-1:0] fwd;
    logic                 busy;
    logic                 ld_use;
    logic                 mdu_raw;
    logic                 mdu_waw;
    logic                 mdu_str;
    logic                 stall_c;
    logic                 issue;

    assign busy = (cnt_q != '0);

    // Per-source forwarding mux select; EX/MEM has priority over MEM/WB.
    always_comb begin
        addr_t ex_src;
        logic  mem_hit;
        logic  wb_hit;
        fwd     = '0;
        ex_src  = '0;
        mem_hit = 1'b0;
        wb_hit  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ex_src  = bus.id_ex_src_addr[i*ADDR_W +: ADDR_W];
            mem_hit = bus.ex_mem_reg_write
                   && (bus.ex_mem_write_reg_addr != '0)
                   && (bus.ex_mem_write_reg_addr == ex_src);
            wb_hit  = bus.mem_wb_reg_write
                   && (bus.mem_wb_write_reg_addr != '0)
                   && (bus.mem_wb_write_reg_addr == ex_src);
            priority case (1'b1)
                mem_hit: fwd[2*i +: 2] = 2'b10;
                wb_hit:  fwd[2*i +: 2] = 2'b01;
                default: fwd[2*i +: 2] = 2'b00;
            endcase
        end
    end

    // Hazard detection on the ID instruction's used, nonzero sources.
    always_comb begin
        addr_t id_src;
        ld_use  = 1'b0;
        mdu_raw = 1'b0;
        id_src  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            id_src = bus.id_src_addr[i*ADDR_W +: ADDR_W];
            if (bus.id_src_used[i] && (id_src != '0)) begin
                if (bus.id_valid && bus.id_ex_is_load
                    && bus.id_ex_reg_write
                    && (bus.id_ex_write_addr == id_src))
                    ld_use = 1'b1;
                if (busy && bus.id_valid && (dst_q == id_src))
                    mdu_raw = 1'b1;
            end
        end
        mdu_waw = busy && bus.id_valid && bus.id_reg_write
               && (dst_q != '0)
               && (bus.id_write_addr == dst_q);
        mdu_str = busy && bus.id_valid && bus.id_is_mdu;
        stall_c = !reset && !bus.flush
               && (ld_use || mdu_raw || mdu_waw || mdu_str);
        issue   = bus.id_valid && bus.id_is_mdu
               && !stall_c && !bus.flush && !reset;
    end

    // MDU destination latch and result countdown; flush never cancels it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            dst_q <= '0;
        end else if (issue) begin
            cnt_q <= LAT_W'(MDU_LAT);
            dst_q <= bus.id_reg_write ? bus.id_write_addr : '0;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset)
            scnt_q <= '0;
        else if (stall_c && (scnt_q != '1))
            scnt_q <= scnt_q + 1'b1;
    end

    assign bus.forward_sel = fwd;
    assign bus.stall       = stall_c;
    assign bus.mdu_busy    = busy;
    assign bus.stall_count = scnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized scoreboard bench for fwd_hazard_unit with a cycle-count
// reference model; a second instance covers a narrow stall counter.
module tb_fwd_hazard_unit;
    localparam int AW  = 5;
    localparam int NS  = 2;
    localparam int LAT = 4;

    typedef struct {
        logic [2*NS-1:0] fs;
        logic            st;
        logic            bz;
        logic [15:0]     sc;
        logic [1:0]      sc2;
    } exp_t;

    logic clk;
    logic reset;

    fwd_hazard_if #(.ADDR_W(AW), .NUM_SRC(NS), .CNT_W(16)) b1 ();
    fwd_hazard_if #(.ADDR_W(AW), .NUM_SRC(NS), .CNT_W(2))  b2 ();

    fwd_hazard_unit #(
        .ADDR_W(AW), .NUM_SRC(NS), .MDU_LAT(LAT), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(b1.slave)
    );

    fwd_hazard_unit #(
        .ADDR_W(AW), .NUM_SRC(NS), .MDU_LAT(LAT), .CNT_W(2)
    ) dut2 (
        .clk(clk), .reset(reset), .bus(b2.slave)
    );

    assign b2.id_valid              = b1.id_valid;
    assign b2.id_src_addr           = b1.id_src_addr;
    assign b2.id_src_used           = b1.id_src_used;
    assign b2.id_reg_write          = b1.id_reg_write;
    assign b2.id_write_addr         = b1.id_write_addr;
    assign b2.id_is_mdu             = b1.id_is_mdu;
    assign b2.flush                 = b1.flush;
    assign b2.id_ex_src_addr        = b1.id_ex_src_addr;
    assign b2.id_ex_reg_write       = b1.id_ex_reg_write;
    assign b2.id_ex_is_load         = b1.id_ex_is_load;
    assign b2.id_ex_write_addr      = b1.id_ex_write_addr;
    assign b2.ex_mem_reg_write      = b1.ex_mem_reg_write;
    assign b2.ex_mem_write_reg_addr = b1.ex_mem_write_reg_addr;
    assign b2.mem_wb_reg_write      = b1.mem_wb_reg_write;
    assign b2.mem_wb_write_reg_addr = b1.mem_wb_write_reg_addr;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state: cycle index, MDU completion cycle, counters
    int      cyc;
    int      mdu_done;
    int      mdu_dst;
    longint  scnt;
    longint  scnt2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1, "watchdog");
    end

    // monitor: pop the expected response and compare every cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (b1.forward_sel !== e.fs) begin
                    bad++;
                    $display("FAIL fwd_sel t=%0t got=%b exp=%b",
                             $time, b1.forward_sel, e.fs);
                end
                total++;
                if (b1.stall !== e.st) begin
                    bad++;
                    $display("FAIL stall t=%0t got=%b exp=%b",
                             $time, b1.stall, e.st);
                end
                total++;
                if (b1.mdu_busy !== e.bz) begin
                    bad++;
                    $display("FAIL mdu_busy t=%0t got=%b exp=%b",
                             $time, b1.mdu_busy, e.bz);
                end
                total++;
                if (b1.stall_count !== e.sc) begin
                    bad++;
                    $display("FAIL stall_count t=%0t got=%0d exp=%0d",
                             $time, b1.stall_count, e.sc);
                end
                total++;
                if (b2.stall_count !== e.sc2) begin
                    bad++;
                    $display("FAIL stall_count_w2 t=%0t got=%0d exp=%0d",
                             $time, b2.stall_count, e.sc2);
                end
            end
        end
    end

    task automatic idle();
        b1.id_valid              = 1'b0;
        b1.id_src_addr           = '0;
        b1.id_src_used           = '0;
        b1.id_reg_write          = 1'b0;
        b1.id_write_addr         = '0;
        b1.id_is_mdu             = 1'b0;
        b1.flush                 = 1'b0;
        b1.id_ex_src_addr        = '0;
        b1.id_ex_reg_write       = 1'b0;
        b1.id_ex_is_load         = 1'b0;
        b1.id_ex_write_addr      = '0;
        b1.ex_mem_reg_write      = 1'b0;
        b1.ex_mem_write_reg_addr = '0;
        b1.mem_wb_reg_write      = 1'b0;
        b1.mem_wb_write_reg_addr = '0;
    endtask

    function automatic logic [AW-1:0] ra();
        if ($urandom_range(0, 3) == 0)
            return AW'($urandom_range(0, 31));
        return AW'($urandom_range(0, 7));
    endfunction

    // model one cycle: predict outputs, push, then advance state at the edge
    task automatic cycle();
        exp_t    e;
        bit      busy;
        bit      haz;
        int      s;
        bit      stl;
        busy = (cyc < mdu_done);
        for (int i = 0; i < NS; i++) begin
            s = int'(b1.id_ex_src_addr[i*AW +: AW]);
            if (b1.ex_mem_reg_write && b1.ex_mem_write_reg_addr != 0
                && int'(b1.ex_mem_write_reg_addr) == s)
                e.fs[2*i +: 2] = 2'b10;
            else if (b1.mem_wb_reg_write && b1.mem_wb_write_reg_addr != 0
                     && int'(b1.mem_wb_write_reg_addr) == s)
                e.fs[2*i +: 2] = 2'b01;
            else
                e.fs[2*i +: 2] = 2'b00;
        end
        haz = 0;
        for (int i = 0; i < NS; i++) begin
            s = int'(b1.id_src_addr[i*AW +: AW]);
            if (b1.id_valid && b1.id_src_used[i] && s != 0) begin
                if (b1.id_ex_is_load && b1.id_ex_reg_write
                    && int'(b1.id_ex_write_addr) == s)
                    haz = 1;
                if (busy && mdu_dst == s)
                    haz = 1;
            end
        end
        if (busy && b1.id_valid && b1.id_reg_write && mdu_dst != 0
            && int'(b1.id_write_addr) == mdu_dst)
            haz = 1;
        if (busy && b1.id_valid && b1.id_is_mdu)
            haz = 1;
        stl  = haz && !reset && !b1.flush;
        e.st  = stl;
        e.bz  = busy;
        e.sc  = 16'(scnt);
        e.sc2 = 2'(scnt2);
        q.push_back(e);
        @(posedge clk);
        if (reset) begin
            mdu_done = 0;
            mdu_dst  = 0;
            scnt     = 0;
            scnt2    = 0;
        end else begin
            if (stl) begin
                if (scnt < 65535) scnt++;
                if (scnt2 < 3) scnt2++;
            end
            if (b1.id_valid && b1.id_is_mdu && !stl && !b1.flush) begin
                mdu_done = cyc + 1 + LAT;
                mdu_dst  = b1.id_reg_write ? int'(b1.id_write_addr) : 0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        cyc = 0; mdu_done = 0; mdu_dst = 0; scnt = 0; scnt2 = 0;
        cycle();
        cycle();
        reset = 1'b0;

        // r5 from both stages on both sources: EX/MEM wins
        b1.ex_mem_reg_write = 1; b1.ex_mem_write_reg_addr = 5;
        b1.mem_wb_reg_write = 1; b1.mem_wb_write_reg_addr = 5;
        b1.id_ex_src_addr = {5'd5, 5'd5};
        cycle();
        // distinct producers, then r0 never forwards
        b1.ex_mem_write_reg_addr = 3; b1.mem_wb_write_reg_addr = 7;
        b1.id_ex_src_addr = {5'd7, 5'd3};
        cycle();
        b1.ex_mem_write_reg_addr = 0; b1.id_ex_src_addr = {5'd7, 5'd0};
        cycle();

        // load-use on src1, unused src1, and flushed
        idle();
        b1.id_valid = 1; b1.id_ex_is_load = 1; b1.id_ex_reg_write = 1;
        b1.id_ex_write_addr = 8; b1.id_src_addr = {5'd8, 5'd1};
        b1.id_src_used = 2'b11;
        cycle();
        b1.id_src_used = 2'b01;
        cycle();
        b1.id_src_used = 2'b11; b1.flush = 1;
        cycle();

        // MDU issue to r9 then a dependent read
        do_reset();
        b1.id_valid = 1; b1.id_is_mdu = 1;
        b1.id_reg_write = 1; b1.id_write_addr = 9;
        cycle();
        b1.id_is_mdu = 0; b1.id_write_addr = 10;
        b1.id_src_addr = {5'd9, 5'd0}; b1.id_src_used = 2'b10;
        for (int k = 0; k < 6; k++) cycle();

        // second MDU op while busy, then reset mid-operation
        idle();
        b1.id_valid = 1; b1.id_is_mdu = 1;
        b1.id_reg_write = 1; b1.id_write_addr = 11;
        cycle();
        b1.id_write_addr = 12;
        for (int k = 0; k < 6; k++) cycle();
        b1.id_valid = 0;
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        idle();
        cycle();

        // held load-use stall saturates the narrow counter
        b1.id_valid = 1; b1.id_ex_is_load = 1; b1.id_ex_reg_write = 1;
        b1.id_ex_write_addr = 4; b1.id_src_addr = {5'd0, 5'd4};
        b1.id_src_used = 2'b01;
        for (int k = 0; k < 6; k++) cycle();
        idle();
        cycle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset                    = ($urandom_range(0, 99) == 0);
            b1.id_valid              = ($urandom_range(0, 7) != 0);
            b1.id_src_addr           = {ra(), ra()};
            b1.id_src_used           = 2'($urandom_range(0, 3));
            b1.id_reg_write          = ($urandom_range(0, 3) != 0);
            b1.id_write_addr         = ra();
            b1.id_is_mdu             = ($urandom_range(0, 5) == 0);
            b1.flush                 = ($urandom_range(0, 9) == 0);
            b1.id_ex_src_addr        = {ra(), ra()};
            b1.id_ex_reg_write       = ($urandom_range(0, 3) != 0);
            b1.id_ex_is_load         = ($urandom_range(0, 3) == 0);
            b1.id_ex_write_addr      = ra();
            b1.ex_mem_reg_write      = ($urandom_range(0, 2) != 0);
            b1.ex_mem_write_reg_addr = ra();
            b1.mem_wb_reg_write      = ($urandom_range(0, 2) != 0);
            b1.mem_wb_write_reg_addr = ra();
            cycle();
        end
        reset = 0;
        idle();
        cycle();

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
